// File: rtl/psum_router_pkg.sv
// Shared types and helpers for the partial-sum write-back router.
package psum_router_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } psum_state_t;

   // Number of output psums produced per tile for a valid (no-padding) convolution
   function automatic int calc_num_psum(input int kernel_size, input int act_size);
      return (act_size - kernel_size + 1) * (act_size - kernel_size + 1);
   endfunction

endpackage

// File: rtl/psum_skid_buf.sv
// Two-entry FIFO decoupling spad read latency from GLB back-pressure.
module psum_skid_buf
   import psum_router_pkg::*;
#(
   parameter int DATA_BITWIDTH = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            push,
   input  logic signed [DATA_BITWIDTH-1:0] push_data,
   input  logic                            pop,
   output logic signed [DATA_BITWIDTH-1:0] head,
   output logic [1:0]                      count
);

   logic signed [DATA_BITWIDTH-1:0] mem_p1 [2];
   logic                            wr_ptr;
   logic                            rd_ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // Storage is not reset; an empty count masks stale entries
   always_ff @(posedge clk) begin
      if (push) mem_p1[wr_ptr] <= push_data;
   end

   assign head = mem_p1[rd_ptr];

endmodule

// File: rtl/router_psum.sv
// Psum write-back router: drains a PE's psum spad into the GLB, one tile per start.
// Optional build macro PSUM_RELU_EN clamps negative words to zero on buffer push.
module router_psum
   import psum_router_pkg::*;
#(
   parameter int DATA_BITWIDTH      = 16,
   parameter int ADDR_BITWIDTH_GLB  = 10,
   parameter int ADDR_BITWIDTH_SPAD = 9,
   parameter int kernel_size        = 3,
   parameter int act_size           = 5,
   parameter int PSUM_READ_ADDR     = 0,
   parameter int PSUM_WRITE_ADDR    = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            write_psum_ctrl,
   output logic                            read_req_spad,
   output logic [ADDR_BITWIDTH_SPAD-1:0]   r_addr_spad,
   input  logic signed [DATA_BITWIDTH-1:0] r_data_spad,
   output logic                            write_req_glb_psum,
   output logic [ADDR_BITWIDTH_GLB-1:0]    w_addr_glb_psum,
   output logic signed [DATA_BITWIDTH-1:0] w_data_glb_psum,
   input  logic                            w_ready_glb_psum,
   output logic                            psum_done,
   output logic                            busy
);

   localparam int NUM_PSUM = calc_num_psum(kernel_size, act_size);
   localparam int CNT_W    = $clog2(NUM_PSUM + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PSUM - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NUM_PSUM);
   localparam logic [ADDR_BITWIDTH_SPAD-1:0] RD_BASE = ADDR_BITWIDTH_SPAD'(PSUM_READ_ADDR);
   localparam logic [ADDR_BITWIDTH_GLB-1:0]  WR_BASE = ADDR_BITWIDTH_GLB'(PSUM_WRITE_ADDR);

   psum_state_t state, state_nxt;
   logic [CNT_W-1:0]                rd_cnt;
   logic [CNT_W-1:0]                wr_cnt;
   logic                            vld_p1;
   logic [1:0]                      buf_count;
   logic signed [DATA_BITWIDTH-1:0] buf_head;
   logic signed [DATA_BITWIDTH-1:0] push_data_p1;
   logic                            buf_nempty;
   logic                            pop;
   logic [2:0]                      credit;

   function automatic logic signed [DATA_BITWIDTH-1:0] psum_clamp(
      input logic signed [DATA_BITWIDTH-1:0] word);
`ifdef PSUM_RELU_EN
      return word[DATA_BITWIDTH-1] ? '0 : word;
`else
      return word;
`endif
   endfunction

   assign buf_nempty         = (buf_count != 2'd0);
   assign write_req_glb_psum = buf_nempty;
   assign pop                = write_req_glb_psum & w_ready_glb_psum;
   // Occupancy the buffer will have after this cycle if no new read is issued
   assign credit             = 3'(buf_count) + 3'(vld_p1) - 3'(pop);
   assign read_req_spad      = (state == DRAIN) && (rd_cnt < CNT_END) && (credit < 3'd2);

   assign r_addr_spad     = RD_BASE + ADDR_BITWIDTH_SPAD'(rd_cnt);
   assign w_addr_glb_psum = WR_BASE + ADDR_BITWIDTH_GLB'(wr_cnt);
   assign w_data_glb_psum = buf_nempty ? buf_head : '0;
   assign psum_done       = (state == DONE);
   assign busy            = (state != IDLE);
   assign push_data_p1    = psum_clamp(r_data_spad);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (write_psum_ctrl) state_nxt = DRAIN;
         DRAIN: if (read_req_spad && (rd_cnt == CNT_LAST)) state_nxt = FLUSH;
         FLUSH: if (pop && (wr_cnt == CNT_LAST)) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // p0 -> p1: read strobe becomes the push strobe when spad data returns
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         rd_cnt <= '0;
         wr_cnt <= '0;
         vld_p1 <= 1'b0;
      end else begin
         state  <= state_nxt;
         vld_p1 <= read_req_spad;
         if ((state == IDLE) && write_psum_ctrl) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
         end else begin
            if (read_req_spad) rd_cnt <= rd_cnt + 1'b1;
            if (pop)           wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   psum_skid_buf #(
      .DATA_BITWIDTH(DATA_BITWIDTH)
   ) u_skid_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (vld_p1),
      .push_data (push_data_p1),
      .pop       (pop),
      .head      (buf_head),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_router_psum.sv
// Directed bench for router_psum: per-cycle vector table plus multi-cycle corner sequences.
module tb_router_psum;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start2;
   logic        w_ready;
   logic        rd, rd2, wr, wr2, done, done2, busy, busy2;
   logic [8:0]  raddr, raddr2;
   logic [15:0] rdata, rdata2;
   logic [9:0]  waddr, waddr2;
   logic [15:0] wdata, wdata2;

   logic [15:0] spad_mem [512];
   logic [9:0]  glb_addr_q[$];
   logic [15:0] glb_data_q[$];
   logic [9:0]  glb2_addr_q[$];
   logic [15:0] glb2_data_q[$];
   int          done_cnt = 0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      bit          rd;
      logic [8:0]  raddr;
      bit          wr;
      logic [9:0]  waddr;
      logic [15:0] wdata;
      bit          done;
      bit          busy;
   } vec_t;

   vec_t tv[14];

   always #5 clk = ~clk;

   router_psum dut (
      .clk(clk), .reset(reset), .write_psum_ctrl(start),
      .read_req_spad(rd), .r_addr_spad(raddr), .r_data_spad(rdata),
      .write_req_glb_psum(wr), .w_addr_glb_psum(waddr), .w_data_glb_psum(wdata),
      .w_ready_glb_psum(w_ready), .psum_done(done), .busy(busy)
   );

   router_psum #(.PSUM_WRITE_ADDR(1020)) dut_wrap (
      .clk(clk), .reset(reset), .write_psum_ctrl(start2),
      .read_req_spad(rd2), .r_addr_spad(raddr2), .r_data_spad(rdata2),
      .write_req_glb_psum(wr2), .w_addr_glb_psum(waddr2), .w_data_glb_psum(wdata2),
      .w_ready_glb_psum(1'b1), .psum_done(done2), .busy(busy2)
   );

   always @(posedge clk) begin
      if (rd)  rdata  <= spad_mem[raddr];
      if (rd2) rdata2 <= spad_mem[raddr2];
      if (wr && w_ready) begin
         glb_addr_q.push_back(waddr);
         glb_data_q.push_back(wdata);
      end
      if (wr2) begin
         glb2_addr_q.push_back(waddr2);
         glb2_data_q.push_back(wdata2);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string name, input int base, input int n, input int first_data);
      chk({name, "_count"}, glb_addr_q.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < glb_addr_q.size()) begin
            chk({name, "_addr"}, glb_addr_q[base+i], i);
            chk({name, "_data"}, glb_data_q[base+i], first_data + i);
         end
      end
   endtask

   task automatic run_tile(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         next_cycle();
         start = (k == 0);
      end
      next_cycle();
      start = 1'b0;
   endtask

   initial begin
      int base, dbase, nlog;
      int exp_wrap[9] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3, 4};

      for (int i = 0; i < 512; i++) spad_mem[i] = 16'(i + 1);
      for (int k = 0; k < 14; k++) begin
         tv[k].rd    = (k >= 1) && (k <= 9);
         tv[k].raddr = 9'(k - 1);
         tv[k].wr    = (k >= 3) && (k <= 11);
         tv[k].waddr = 10'(k - 3);
         tv[k].wdata = tv[k].wr ? 16'(k - 2) : 16'h0;
         tv[k].done  = (k == 12);
         tv[k].busy  = (k >= 1) && (k <= 12);
      end

      reset = 1'b0; start = 1'b0; start2 = 1'b0; w_ready = 1'b1;
      repeat (3) next_cycle();
      @(negedge clk);
      chk("rst_rd", rd, 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_wr", wr, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      next_cycle();
      reset = 1'b1;
      repeat (2) next_cycle();

      // Full-rate tile, cycle by cycle
      base = glb_addr_q.size();
      dbase = done_cnt;
      for (int k = 0; k < 14; k++) begin
         next_cycle();
         start = (k == 0);
         w_ready = 1'b1;
         @(negedge clk);
         chk("t1_rd", rd, tv[k].rd);
         if (tv[k].rd) chk("t1_raddr", raddr, tv[k].raddr);
         chk("t1_wr", wr, tv[k].wr);
         if (tv[k].wr) chk("t1_waddr", waddr, tv[k].waddr);
         chk("t1_wdata", wdata, tv[k].wdata);
         chk("t1_done", done, tv[k].done);
         chk("t1_busy", busy, tv[k].busy);
      end
      start = 1'b0;
      chk_log("t1_log", base, 9, 1);
      chk("t1_done_cnt", done_cnt - dbase, 1);

      // Back-pressure in cycles 5..7
      base = glb_addr_q.size();
      dbase = done_cnt;
      for (int k = 0; k < 22; k++) begin
         next_cycle();
         start = (k == 0);
         w_ready = !((k >= 5) && (k <= 7));
         @(negedge clk);
         if ((k >= 5) && (k <= 7)) begin
            chk("t2_stall_wr", wr, 1);
            chk("t2_stall_waddr", waddr, 2);
            chk("t2_stall_wdata", wdata, 3);
            chk("t2_stall_rd", rd, 0);
         end
         if (k == 8) chk("t2_resume_rd", rd, 1);
      end
      start = 1'b0; w_ready = 1'b1;
      chk_log("t2_log", base, 9, 1);
      chk("t2_done_cnt", done_cnt - dbase, 1);

      // Start re-asserted mid-tile and held through DONE
      base = glb_addr_q.size();
      dbase = done_cnt;
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         start = (k == 0) || ((k >= 4) && (k <= 12));
         @(negedge clk);
         if (k == 12) chk("t3_done_c12", done, 1);
         if (k == 13) chk("t3_idle_c13", busy, 0);
      end
      start = 1'b0;
      chk_log("t3_log", base, 9, 1);
      chk("t3_done_cnt", done_cnt - dbase, 1);
      base = glb_addr_q.size();
      dbase = done_cnt;
      run_tile(16);
      chk_log("t3_second_log", base, 9, 1);
      chk("t3_second_done", done_cnt - dbase, 1);

      // Reset asserted in cycle 6 of a tile
      dbase = done_cnt;
      nlog = 0;
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         start = (k == 0);
         reset = (k != 6);
         @(negedge clk);
         if (k == 7) begin
            chk("t4_rd", rd, 0);
            chk("t4_raddr", raddr, 0);
            chk("t4_wr", wr, 0);
            chk("t4_waddr", waddr, 0);
            chk("t4_wdata", wdata, 0);
            chk("t4_done", done, 0);
            chk("t4_busy", busy, 0);
            nlog = glb_addr_q.size();
         end
      end
      reset = 1'b1;
      chk("t4_no_writes", glb_addr_q.size() - nlog, 0);
      chk("t4_no_done", done_cnt - dbase, 0);
      base = glb_addr_q.size();
      run_tile(16);
      chk_log("t4_restart_log", base, 9, 1);

      // GLB address wrap on the second instance
      base = glb2_addr_q.size();
      for (int k = 0; k < 16; k++) begin
         next_cycle();
         start2 = (k == 0);
      end
      start2 = 1'b0;
      chk("t5_count", glb2_addr_q.size() - base, 9);
      for (int i = 0; i < 9; i++) begin
         if (base + i < glb2_addr_q.size()) begin
            chk("t5_addr", glb2_addr_q[base+i], exp_wrap[i]);
            chk("t5_data", glb2_data_q[base+i], i + 1);
         end
      end

      // Negative and positive words through the clamp path
      spad_mem[0] = 16'hFFF0;
      spad_mem[1] = 16'h0010;
      base = glb_addr_q.size();
      run_tile(16);
      chk("t6_count", glb_addr_q.size() - base, 9);
      if (glb_data_q.size() >= base + 2) begin
`ifdef PSUM_RELU_EN
         chk("t6_neg", glb_data_q[base], 16'h0000);
`else
         chk("t6_neg", glb_data_q[base], 16'hFFF0);
`endif
         chk("t6_pos", glb_data_q[base+1], 16'h0010);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
